// File: rtl/number_hit_scheduler.sv
// Round-robin hit scheduler for the number sprites: captures hits, scores them, hides and respawns digits.
// Optional macro RANDOM_DIGITS_EN replaces the (d+3) mod 10 respawn digit with an LFSR-derived digit.
module number_hit_scheduler #(
  parameter int NUMBERS        = 3,
  parameter int RESPAWN_FRAMES = 450,
  parameter int TIMER_W        = 9,
  localparam int IDX_W         = (NUMBERS > 1) ? $clog2(NUMBERS) : 1
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic [NUMBERS-1:0]      singleHit,
  output logic [NUMBERS-1:0][3:0] numbersToShow,
  output logic [NUMBERS-1:0]      showNum,
  output logic                    scorePulse,
  output logic [3:0]              scoreValue,
  output logic [IDX_W-1:0]        grantIdx,
  output logic [15:0]             scoreTotal
);

  typedef enum logic [1:0] {IDLE, GRANT, UPDATE} state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                grant_q, grant_d;
  logic [IDX_W-1:0]                ptr_q, ptr_d;
  logic [NUMBERS-1:0]              pending_q, pending_d;
  logic [NUMBERS-1:0]              show_q, show_d;
  logic [NUMBERS-1:0][3:0]         digit_q, digit_d;
  logic [NUMBERS-1:0][TIMER_W-1:0] timer_q, timer_d;
  logic                            pulse_q, pulse_d;
  logic [3:0]                      value_q, value_d;
  logic [15:0]                     total_q, total_d;
  logic [IDX_W-1:0]                sel;
  logic                            sel_found;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

`ifdef RANDOM_DIGITS_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) lfsr_q <= 8'hA5;
    else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Fold the low nibble into 0-9 and never respawn with the same digit.
  function automatic logic [3:0] next_digit(input logic [3:0] d, input logic [7:0] l);
    logic [3:0] r;
    r = (l[3:0] < 4'd10) ? l[3:0] : l[3:0] - 4'd10;
    if (r == d) r = (r == 4'd9) ? 4'd0 : r + 4'd1;
    return r;
  endfunction
`else
  function automatic logic [3:0] next_digit(input logic [3:0] d);
    return (d >= 4'd7) ? d - 4'd7 : d + 4'd3;
  endfunction
`endif

  // First pending index after the last grant, wrapping at NUMBERS.
  always_comb begin
    int idx;
    idx       = 0;
    sel       = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= NUMBERS; k++) begin
      idx = (int'(ptr_q) + k) % NUMBERS;
      if (!sel_found && pending_q[idx]) begin
        sel_found = 1'b1;
        sel       = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    pending_d = pending_q | (singleHit & show_q);
    show_d    = show_q;
    digit_d   = digit_q;
    timer_d   = timer_q;
    pulse_d   = pulse_q;
    value_d   = value_q;
    total_d   = total_q;

    if (startOfFrame) begin
      for (int i = 0; i < NUMBERS; i++) begin
        if (timer_q[i] != '0) begin
          timer_d[i] = timer_q[i] - 1'b1;
          if (timer_q[i] == TIMER_W'(1)) show_d[i] = 1'b1;
        end
      end
    end

    // GRANT assignments come after the frame decrement so the reload wins.
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          grant_d = sel;
          state_d = GRANT;
        end
      end
      GRANT: begin
        pending_d[grant_q] = 1'b0;
        show_d[grant_q]    = 1'b0;
        timer_d[grant_q]   = TIMER_W'(RESPAWN_FRAMES);
        pulse_d            = 1'b1;
        value_d            = digit_q[grant_q];
        total_d            = sat_add(total_q, digit_q[grant_q]);
        ptr_d              = grant_q;
        state_d            = UPDATE;
      end
      UPDATE: begin
        pulse_d = 1'b0;
`ifdef RANDOM_DIGITS_EN
        digit_d[grant_q] = next_digit(digit_q[grant_q], lfsr_q);
`else
        digit_d[grant_q] = next_digit(digit_q[grant_q]);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= IDX_W'(NUMBERS - 1);
      pending_q <= '0;
      show_q    <= '1;
      for (int i = 0; i < NUMBERS; i++) digit_q[i] <= 4'(i % 10);
      timer_q   <= '0;
      pulse_q   <= 1'b0;
      value_q   <= '0;
      total_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      show_q    <= show_d;
      digit_q   <= digit_d;
      timer_q   <= timer_d;
      pulse_q   <= pulse_d;
      value_q   <= value_d;
      total_q   <= total_d;
    end
  end

  assign numbersToShow = digit_q;
  assign showNum       = show_q;
  assign scorePulse    = pulse_q;
  assign scoreValue    = value_q;
  assign grantIdx      = (pulse_q) ? grant_q : '0;
  assign scoreTotal    = total_q;

endmodule

// File: tb/tb_number_hit_scheduler.sv
// Directed bench for number_hit_scheduler (default parameters, RANDOM_DIGITS_EN undefined).
module tb_number_hit_scheduler;

  logic            clk = 1'b0;
  logic            resetN;
  logic            startOfFrame;
  logic [2:0]      singleHit;
  logic [2:0][3:0] numbersToShow;
  logic [2:0]      showNum;
  logic            scorePulse;
  logic [3:0]      scoreValue;
  logic [1:0]      grantIdx;
  logic [15:0]     scoreTotal;

  int n_vec = 0;
  int n_bad = 0;
  int pulse_cnt = 0;
  int base;

  number_hit_scheduler dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .singleHit    (singleHit),
    .numbersToShow(numbersToShow),
    .showNum      (showNum),
    .scorePulse   (scorePulse),
    .scoreValue   (scoreValue),
    .grantIdx     (grantIdx),
    .scoreTotal   (scoreTotal)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (scorePulse === 1'b1) pulse_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step();
  endtask

  task automatic do_reset();
    resetN       = 1'b0;
    singleHit    = '0;
    startOfFrame = 1'b0;
    step(2);
    resetN = 1'b1;
    step();
    pulse_cnt = 0;
  endtask

  initial begin
    resetN       = 1'b0;
    singleHit    = '0;
    startOfFrame = 1'b0;

    // 1: reset state, idle without hits
    do_reset();
    chk("rst_show", 32'(showNum), 32'h7);
    chk("rst_digits", 32'(numbersToShow), 32'h210);
    chk("rst_total", 32'(scoreTotal), 32'h0);
    chk("rst_pulse", 32'(scorePulse), 32'h0);
    step(10);
    chk("idle_pulse_cnt", 32'(pulse_cnt), 32'h0);
    chk("idle_show", 32'(showNum), 32'h7);

    // 2: single hit on number 1
    do_reset();
    singleHit = 3'b010;
    step();
    singleHit = 3'b000;
    step();
    chk("t2_pulse_early", 32'(scorePulse), 32'h0);
    step();
    chk("t2_pulse", 32'(scorePulse), 32'h1);
    chk("t2_grant", 32'(grantIdx), 32'h1);
    chk("t2_value", 32'(scoreValue), 32'h1);
    chk("t2_show", 32'(showNum), 32'h5);
    chk("t2_total", 32'(scoreTotal), 32'h1);
    step();
    chk("t2_pulse_end", 32'(scorePulse), 32'h0);
    chk("t2_digits", 32'(numbersToShow), 32'h240);
    step(5);
    chk("t2_pulse_cnt", 32'(pulse_cnt), 32'h1);

    // 3: all three hit together, serviced 0,1,2 three cycles apart
    do_reset();
    singleHit = 3'b111;
    step();
    singleHit = 3'b000;
    for (int j = 2; j <= 10; j++) begin
      step();
      if (j == 3 || j == 6 || j == 9) begin
        chk("t3_pulse_hi", 32'(scorePulse), 32'h1);
        chk("t3_grant", 32'(grantIdx), 32'(j / 3 - 1));
        chk("t3_value", 32'(scoreValue), 32'(j / 3 - 1));
      end else begin
        chk("t3_pulse_lo", 32'(scorePulse), 32'h0);
      end
    end
    chk("t3_total", 32'(scoreTotal), 32'h3);
    chk("t3_show", 32'(showNum), 32'h0);
    chk("t3_digits", 32'(numbersToShow), 32'h543);

    // 4: respawn after exactly 450 frames; held hits on hidden number ignored
    do_reset();
    singleHit = 3'b001;
    step();
    singleHit = 3'b000;
    step(3);
    chk("t4_hidden", 32'(showNum), 32'h6);
    base = pulse_cnt;
    singleHit = 3'b001;
    for (int f = 0; f < 449; f++) frame();
    singleHit = 3'b000;
    chk("t4_show_449", 32'(showNum), 32'h6);
    chk("t4_no_pulse_hidden", 32'(pulse_cnt), 32'(base));
    frame();
    chk("t4_show_450", 32'(showNum), 32'h7);

    // 5: frame tick coinciding with GRANT does not shorten the reloaded timer
    do_reset();
    singleHit = 3'b010;
    step();
    singleHit = 3'b000;
    step();
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    chk("t5_pulse", 32'(scorePulse), 32'h1);
    chk("t5_hidden", 32'(showNum), 32'h5);
    for (int f = 0; f < 449; f++) frame();
    chk("t5_show_449", 32'(showNum), 32'h5);
    frame();
    chk("t5_show_450", 32'(showNum), 32'h7);

    // 6: asynchronous reset during UPDATE drops pending hits
    do_reset();
    singleHit = 3'b110;
    step();
    singleHit = 3'b000;
    step(2);
    chk("t6_pre_pulse", 32'(scorePulse), 32'h1);
    chk("t6_pre_total", 32'(scoreTotal), 32'h1);
    #2;
    resetN = 1'b0;
    #1;
    chk("t6_rst_pulse", 32'(scorePulse), 32'h0);
    chk("t6_rst_show", 32'(showNum), 32'h7);
    chk("t6_rst_digits", 32'(numbersToShow), 32'h210);
    chk("t6_rst_total", 32'(scoreTotal), 32'h0);
    chk("t6_rst_grant", 32'(grantIdx), 32'h0);
    chk("t6_rst_value", 32'(scoreValue), 32'h0);
    #2;
    resetN = 1'b1;
    pulse_cnt = 0;
    step(8);
    chk("t6_no_stale", 32'(pulse_cnt), 32'h0);
    chk("t6_show_after", 32'(showNum), 32'h7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
